// File: rtl/riscv_if2id_jalr_stage_pkg.sv
// Shared constants for the IF/ID stage: opcode and NOP encodings, JALR forward
// select codes and the wrong-path drop FSM states.
package riscv_if2id_jalr_stage_pkg;

  localparam logic [6:0]  OpcJalr  = 7'b1100111;
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic [1:0] FwdRf    = 2'b00;
  localparam logic [1:0] FwdExMem = 2'b01;
  localparam logic [1:0] FwdMemWb = 2'b10;

  typedef enum logic [0:0] {
    StIdle,
    StDrop
  } jalr_state_e;

  function automatic logic is_jalr(input logic [6:0] opcode);
    return opcode == OpcJalr;
  endfunction

endpackage

// File: rtl/riscv_if_skid_buf.sv
// One-entry skid register; clear wins over push, push wins over pop.
module riscv_if_skid_buf #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic             valid,
  output logic [Width-1:0] data
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/riscv_if2id_jalr_stage.sv
// IF/ID pipeline register with skid buffer, JALR target resolution in ID and a
// one-beat wrong-path drop after each redirect.
module riscv_if2id_jalr_stage
  import riscv_if2id_jalr_stage_pkg::*;
#(
  parameter int unsigned IBUS_DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned RF_ADDR_WIDTH   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [IBUS_DATA_WIDTH-1:0] if_instr,
  input  logic [PC_WIDTH-1:0]        if_pc,
  input  logic                       stall_jalr,
  input  logic                       stall_other,
  input  logic [1:0]                 fwd_jalr,
  input  logic [XLEN-1:0]            rf_rs1_data,
  input  logic [XLEN-1:0]            alu_result_ex2mem_ff,
  input  logic [XLEN-1:0]            wb_data_mem2wb,
  input  logic                       flush_ex,
  output logic [IBUS_DATA_WIDTH-1:0] instr_if2id_ff,
  output logic [PC_WIDTH-1:0]        pc_if2id_ff,
  output logic                       valid_if2id_ff,
  output logic                       redirect_valid,
  output logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       jalr_misalign
);

  localparam int unsigned SkidWidth = IBUS_DATA_WIDTH + PC_WIDTH;
  localparam logic [IBUS_DATA_WIDTH-1:0] Nop = IBUS_DATA_WIDTH'(NopInstr);

  jalr_state_e                state_q;
  logic                       valid_q;
  logic [IBUS_DATA_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]        pc_q;
  logic                       redirect_valid_q;
  logic [PC_WIDTH-1:0]        redirect_pc_q;
  logic                       jalr_misalign_q;

  logic                       skid_valid;
  logic [SkidWidth-1:0]       skid_data;
  logic [IBUS_DATA_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]        skid_pc;

  logic                       hold;
  logic                       accept;
  logic                       resolve;
  logic                       beat_live;
  logic [XLEN-1:0]            rs1;
  logic [XLEN-1:0]            imm;
  logic [XLEN-1:0]            sum;
  logic [PC_WIDTH-1:0]        target;
  logic                       unused_rs1_addr;

  assign hold     = stall_jalr | stall_other;
  assign if_ready = ~skid_valid;
  assign accept   = if_valid & if_ready;
  assign resolve  = valid_q & is_jalr(instr_q[6:0]) & ~hold & (state_q == StIdle);
  // Beats accepted while dropping, redirecting or flushing are wrong-path.
  assign beat_live = accept & (state_q == StIdle) & ~resolve & ~flush_ex;

  // rs1 address is decoded by the hazard unit; forwarding arrives pre-selected.
  assign unused_rs1_addr = ^instr_q[15 +: RF_ADDR_WIDTH];

  always_comb begin
    rs1 = rf_rs1_data;
    case (fwd_jalr)
      FwdExMem: rs1 = alu_result_ex2mem_ff;
      FwdMemWb: rs1 = wb_data_mem2wb;
      default:  rs1 = rf_rs1_data;
    endcase
  end

  assign imm    = {{(XLEN - 12){instr_q[31]}}, instr_q[31:20]};
  assign sum    = rs1 + imm;
  assign target = {sum[PC_WIDTH-1:1], 1'b0};

  riscv_if_skid_buf #(
    .Width(SkidWidth)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_ex | resolve),
    .push     (beat_live & hold),
    .pop      (~hold),
    .push_data({if_instr, if_pc}),
    .valid    (skid_valid),
    .data     (skid_data)
  );

  assign {skid_instr, skid_pc} = skid_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= Nop;
      pc_q    <= '0;
    end else if (flush_ex || resolve) begin
      // On resolve the JALR moves on and ID is left empty for the drop beat.
      valid_q <= 1'b0;
      instr_q <= Nop;
    end else if (!hold) begin
      if (skid_valid) begin
        valid_q <= 1'b1;
        instr_q <= skid_instr;
        pc_q    <= skid_pc;
      end else if (beat_live) begin
        valid_q <= 1'b1;
        instr_q <= if_instr;
        pc_q    <= if_pc;
      end else begin
        valid_q <= 1'b0;
        instr_q <= Nop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      jalr_misalign_q  <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      jalr_misalign_q  <= 1'b0;
      if (flush_ex) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (resolve) begin
              state_q          <= StDrop;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= target;
              jalr_misalign_q  <= target[1];
            end
          end
          StDrop: begin
            if (accept) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign instr_if2id_ff = instr_q;
  assign pc_if2id_ff    = pc_q;
  assign valid_if2id_ff = valid_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign jalr_misalign  = jalr_misalign_q;

endmodule

// File: tb/tb_riscv_if2id_jalr_stage.sv
// Directed bench for the IF/ID JALR stage: streaming, skid, JALR resolve, flush, reset.
module tb_riscv_if2id_jalr_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        stall_jalr;
  logic        stall_other;
  logic [1:0]  fwd_jalr;
  logic [31:0] rf_rs1_data;
  logic [31:0] alu_result_ex2mem_ff;
  logic [31:0] wb_data_mem2wb;
  logic        flush_ex;
  logic [31:0] instr_if2id_ff;
  logic [31:0] pc_if2id_ff;
  logic        valid_if2id_ff;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        jalr_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_if2id_jalr_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_valid            (if_valid),
    .if_ready            (if_ready),
    .if_instr            (if_instr),
    .if_pc               (if_pc),
    .stall_jalr          (stall_jalr),
    .stall_other         (stall_other),
    .fwd_jalr            (fwd_jalr),
    .rf_rs1_data         (rf_rs1_data),
    .alu_result_ex2mem_ff(alu_result_ex2mem_ff),
    .wb_data_mem2wb      (wb_data_mem2wb),
    .flush_ex            (flush_ex),
    .instr_if2id_ff      (instr_if2id_ff),
    .pc_if2id_ff         (pc_if2id_ff),
    .valid_if2id_ff      (valid_if2id_ff),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .jalr_misalign       (jalr_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd5, 3'b000, 5'd0, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_if2id_ff), 32'd0);
    check_eq({tag, "_instr"}, instr_if2id_ff, Nop);
    check_eq({tag, "_pc"}, pc_if2id_ff, 32'h0);
    check_eq({tag, "_ready"}, 32'(if_ready), 32'd1);
    check_eq({tag, "_rv"}, 32'(redirect_valid), 32'd0);
    check_eq({tag, "_rpc"}, redirect_pc, 32'h0);
    check_eq({tag, "_mis"}, 32'(jalr_misalign), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    beat(1'b0, 32'h0, 32'h0);
    stall_jalr = 1'b0;
    stall_other = 1'b0;
    fwd_jalr = 2'b00;
    rf_rs1_data = '0;
    alu_result_ex2mem_ff = '0;
    wb_data_mem2wb = '0;
    flush_ex = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;

    // Streaming: each beat appears in ID one cycle after acceptance.
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, enc_addi(12'(i + 1)), 32'(4 * i));
      step();
      check_eq("stream_valid", 32'(valid_if2id_ff), 32'd1);
      check_eq("stream_instr", instr_if2id_ff, enc_addi(12'(i + 1)));
      check_eq("stream_pc", pc_if2id_ff, 32'(4 * i));
      check_eq("stream_ready", 32'(if_ready), 32'd1);
    end
    beat(1'b0, 32'h0, 32'h0);
    step();
    check_eq("stream_idle_valid", 32'(valid_if2id_ff), 32'd0);
    check_eq("stream_idle_instr", instr_if2id_ff, Nop);

    // Skid: B is captured while A is held, C waits for if_ready.
    beat(1'b1, enc_addi(12'h10), 32'h10);
    step();
    stall_other = 1'b1;
    beat(1'b1, enc_addi(12'h14), 32'h14);
    step();
    check_eq("skid_hold_pc", pc_if2id_ff, 32'h10);
    check_eq("skid_ready_low", 32'(if_ready), 32'd0);
    beat(1'b1, enc_addi(12'h18), 32'h18);
    step();
    step();
    check_eq("skid_hold2_pc", pc_if2id_ff, 32'h10);
    check_eq("skid_ready_low2", 32'(if_ready), 32'd0);
    stall_other = 1'b0;
    step();
    check_eq("skid_drain_pc", pc_if2id_ff, 32'h14);
    check_eq("skid_drain_instr", instr_if2id_ff, enc_addi(12'h14));
    check_eq("skid_ready_back", 32'(if_ready), 32'd1);
    step();
    check_eq("skid_next_pc", pc_if2id_ff, 32'h18);
    check_eq("skid_next_valid", 32'(valid_if2id_ff), 32'd1);
    beat(1'b0, 32'h0, 32'h0);
    step();

    // JALR with EX/MEM forward: 0x1001 + 0x10 -> 0x1010.
    beat(1'b1, enc_jalr(12'h010), 32'h40);
    step();
    check_eq("jf_id_jalr", instr_if2id_ff, enc_jalr(12'h010));
    fwd_jalr = 2'b01;
    alu_result_ex2mem_ff = 32'h1001;
    beat(1'b1, enc_addi(12'h44), 32'h44);
    step();
    check_eq("jf_rv", 32'(redirect_valid), 32'd1);
    check_eq("jf_rpc", redirect_pc, 32'h1010);
    check_eq("jf_mis", 32'(jalr_misalign), 32'd0);
    check_eq("jf_id_empty", 32'(valid_if2id_ff), 32'd0);
    beat(1'b1, enc_addi(12'h48), 32'h48);
    step();
    check_eq("jf_rv_pulse", 32'(redirect_valid), 32'd0);
    check_eq("jf_drop", 32'(valid_if2id_ff), 32'd0);
    beat(1'b1, enc_addi(12'h7), 32'h1010);
    step();
    check_eq("jf_target_valid", 32'(valid_if2id_ff), 32'd1);
    check_eq("jf_target_pc", pc_if2id_ff, 32'h1010);
    beat(1'b0, 32'h0, 32'h0);
    fwd_jalr = 2'b00;

    // Stalled JALR resolves only when stall_jalr drops: 0x2002 - 2 -> 0x2000.
    beat(1'b1, enc_jalr(12'hFFE), 32'h80);
    step();
    beat(1'b0, 32'h0, 32'h0);
    stall_jalr = 1'b1;
    fwd_jalr = 2'b10;
    wb_data_mem2wb = 32'h2002;
    step();
    check_eq("js_rv_stall1", 32'(redirect_valid), 32'd0);
    check_eq("js_id_held", instr_if2id_ff, enc_jalr(12'hFFE));
    step();
    check_eq("js_rv_stall2", 32'(redirect_valid), 32'd0);
    stall_jalr = 1'b0;
    step();
    check_eq("js_rv", 32'(redirect_valid), 32'd1);
    check_eq("js_rpc", redirect_pc, 32'h2000);
    check_eq("js_mis", 32'(jalr_misalign), 32'd0);
    beat(1'b1, enc_addi(12'h84), 32'h84);
    step();
    check_eq("js_drop", 32'(valid_if2id_ff), 32'd0);
    beat(1'b0, 32'h0, 32'h0);
    fwd_jalr = 2'b00;

    // Wrap and misalign: 0xFFFFFFFE + 4 -> 0x2, then reset while in DROP.
    rf_rs1_data = 32'hFFFF_FFFE;
    beat(1'b1, enc_jalr(12'h004), 32'hC0);
    step();
    beat(1'b0, 32'h0, 32'h0);
    step();
    check_eq("jw_rv", 32'(redirect_valid), 32'd1);
    check_eq("jw_rpc", redirect_pc, 32'h2);
    check_eq("jw_mis", 32'(jalr_misalign), 32'd1);
    rst = 1'b1;
    beat(1'b1, enc_addi(12'h99), 32'hC4);
    step();
    check_reset_state("rst_drop");
    rst = 1'b0;
    beat(1'b1, enc_addi(12'h100), 32'h100);
    step();
    check_eq("rst_idle_valid", 32'(valid_if2id_ff), 32'd1);
    check_eq("rst_idle_pc", pc_if2id_ff, 32'h100);

    // Flush in the resolve cycle suppresses the redirect and the drop.
    rf_rs1_data = 32'h300;
    beat(1'b1, enc_jalr(12'h008), 32'h104);
    step();
    flush_ex = 1'b1;
    beat(1'b1, enc_addi(12'h108), 32'h108);
    step();
    check_eq("fl_rv", 32'(redirect_valid), 32'd0);
    check_eq("fl_valid", 32'(valid_if2id_ff), 32'd0);
    check_eq("fl_instr", instr_if2id_ff, Nop);
    check_eq("fl_ready", 32'(if_ready), 32'd1);
    flush_ex = 1'b0;
    beat(1'b1, enc_addi(12'h10C), 32'h10C);
    step();
    check_eq("fl_idle_valid", 32'(valid_if2id_ff), 32'd1);
    check_eq("fl_idle_pc", pc_if2id_ff, 32'h10C);

    // Flush empties an occupied skid.
    stall_other = 1'b1;
    beat(1'b1, enc_addi(12'h110), 32'h110);
    step();
    check_eq("fs_ready_low", 32'(if_ready), 32'd0);
    beat(1'b0, 32'h0, 32'h0);
    flush_ex = 1'b1;
    step();
    check_eq("fs_ready", 32'(if_ready), 32'd1);
    check_eq("fs_valid", 32'(valid_if2id_ff), 32'd0);
    flush_ex = 1'b0;
    stall_other = 1'b0;
    step();
    check_eq("fs_no_skid", 32'(valid_if2id_ff), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
